// File: rtl/pll_sup_pkg.sv
// Shared types and defaults for the PLL lock supervisor: state encoding,
// default cycle counts and status counter widths.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    PRST = 3'd0,
    WAIT = 3'd1,
    SETL = 3'd2,
    RUN  = 3'd3,
    FAIL = 3'd4
  } state_t;

  localparam int DEF_RST_PULSE    = 16;
  localparam int DEF_LOCK_TIMEOUT = 50000;
  localparam int DEF_SETTLE       = 1024;
  localparam int DEF_LOSS_FILTER  = 4;
  localparam int DEF_MAX_RETRIES  = 4;
  localparam int DEF_CNT_W        = 16;

  localparam int RETRY_W    = 3;
  localparam int LOSS_CNT_W = 8;

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// PLL-facing and core-facing signals of the lock supervisor; master is the
// supervisor, slave is the surrounding system.
interface pll_lock_supervisor_if;
  import pll_sup_pkg::*;

  logic                  pll_locked;
  logic                  restart;
  logic                  pll_rst;
  logic                  sys_reset;
  logic                  ready;
  logic                  fail;
  logic [RETRY_W-1:0]    retry_cnt;
  logic [LOSS_CNT_W-1:0] lock_loss_cnt;

  modport master (
    input  pll_locked, restart,
    output pll_rst, sys_reset, ready, fail, retry_cnt, lock_loss_cnt
  );

  modport slave (
    output pll_locked, restart,
    input  pll_rst, sys_reset, ready, fail, retry_cnt, lock_loss_cnt
  );

endinterface

// File: rtl/pll_lock_supervisor_sync2.sv
// Generic two-flop synchronizer with synchronous clear, for bringing
// asynchronous level signals into the local clock domain.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL bring-up sequencer on refclk: pulses PLL reset, waits for lock with
// timeout/retry, holds core reset through a settle window, and re-sequences on lock loss.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_PULSE    = DEF_RST_PULSE,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int SETTLE       = DEF_SETTLE,
  parameter int LOSS_FILTER  = DEF_LOSS_FILTER,
  parameter int MAX_RETRIES  = DEF_MAX_RETRIES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input logic                  refclk,
  input logic                  rst,
  pll_lock_supervisor_if.master bus
);

  localparam int LF_W = $clog2(LOSS_FILTER + 1);

  localparam logic [CNT_W-1:0] C_RST_LOAD  = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0] C_LOCK_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_SETL_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [LF_W-1:0]  C_LF_LAST   = LF_W'(LOSS_FILTER - 1);

  function automatic logic [RETRY_W-1:0] sat_inc_retry(input logic [RETRY_W-1:0] v);
    return (v == {RETRY_W{1'b1}}) ? v : v + RETRY_W'(1);
  endfunction

  function automatic logic [LOSS_CNT_W-1:0] sat_inc_loss(input logic [LOSS_CNT_W-1:0] v);
    return (v == {LOSS_CNT_W{1'b1}}) ? v : v + LOSS_CNT_W'(1);
  endfunction

  logic                  w_lk;
  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [LF_W-1:0]       r_loss, w_loss_nxt;
  logic [RETRY_W-1:0]    r_retry, w_retry_nxt, w_retry_inc;
  logic [LOSS_CNT_W-1:0] r_lol, w_lol_nxt;
  logic                  r_pll_rst, r_sys_reset, r_ready, r_fail;

  sync2 #(.WIDTH(1)) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .i_d (bus.pll_locked),
    .o_q (w_lk)
  );

  // Next-state logic; the zero test precedes the decrement so the counter never wraps.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = (r_cnt != '0) ? r_cnt - CNT_W'(1) : r_cnt;
    w_loss_nxt  = '0;
    w_retry_nxt = r_retry;
    w_lol_nxt   = r_lol;
    w_retry_inc = sat_inc_retry(r_retry);

    if (bus.restart && (r_state != PRST)) begin
      w_state_nxt = PRST;
      w_cnt_nxt   = C_RST_LOAD;
      w_retry_nxt = '0;
    end else begin
      case (r_state)
        PRST: begin
          if (r_cnt == '0) begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = C_LOCK_LOAD;
          end
        end
        WAIT: begin
          if (w_lk) begin
            w_state_nxt = SETL;
            w_cnt_nxt   = C_SETL_LOAD;
          end else if (r_cnt == '0) begin
            w_retry_nxt = w_retry_inc;
            if (int'(w_retry_inc) >= MAX_RETRIES) begin
              w_state_nxt = FAIL;
            end else begin
              w_state_nxt = PRST;
              w_cnt_nxt   = C_RST_LOAD;
            end
          end
        end
        SETL: begin
          if (!w_lk) begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = C_LOCK_LOAD;
          end else if (r_cnt == '0) begin
            w_state_nxt = RUN;
            w_retry_nxt = '0;
          end
        end
        RUN: begin
          if (!w_lk) begin
            if (r_loss == C_LF_LAST) begin
              w_lol_nxt   = sat_inc_loss(r_lol);
              w_state_nxt = PRST;
              w_cnt_nxt   = C_RST_LOAD;
            end else begin
              w_loss_nxt = r_loss + LF_W'(1);
            end
          end
        end
        FAIL: begin
          w_state_nxt = FAIL;
        end
        default: begin
          w_state_nxt = PRST;
          w_cnt_nxt   = C_RST_LOAD;
        end
      endcase
    end
  end

  // State, counters and outputs; outputs follow the state with one cycle of lag.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state     <= PRST;
      r_cnt       <= C_RST_LOAD;
      r_loss      <= '0;
      r_retry     <= '0;
      r_lol       <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_reset <= 1'b1;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_loss      <= w_loss_nxt;
      r_retry     <= w_retry_nxt;
      r_lol       <= w_lol_nxt;
      r_pll_rst   <= (r_state == PRST);
      r_sys_reset <= (r_state != RUN);
      r_ready     <= (r_state == RUN);
      r_fail      <= (r_state == FAIL);
    end
  end

  assign bus.pll_rst       = r_pll_rst;
  assign bus.sys_reset     = r_sys_reset;
  assign bus.ready         = r_ready;
  assign bus.fail          = r_fail;
  assign bus.retry_cnt     = r_retry;
  assign bus.lock_loss_cnt = r_lol;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: a vector table for power-up and
// short dropouts, then hand sequences for loss, glitch, timeout, restart and reset corners.
module tb_pll_lock_supervisor;
  import pll_sup_pkg::*;

  logic refclk = 1'b0;
  logic rst;

  pll_lock_supervisor_if bus ();

  always #5 refclk = ~refclk;

  pll_lock_supervisor #(
    .RST_PULSE    (16),
    .LOCK_TIMEOUT (100),
    .SETTLE       (1024),
    .LOSS_FILTER  (4),
    .MAX_RETRIES  (4),
    .CNT_W        (16)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .bus    (bus)
  );

  typedef struct {
    logic       rst;
    logic       locked;
    logic       restart;
    int         cyc;
    logic       pll_rst;
    logic       sys_reset;
    logic       ready;
    logic       fail;
    logic [2:0] retry;
    logic [7:0] loss;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int rises;
  logic prev_pr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string p, input logic e_pr, input logic e_sr, input logic e_rd,
                         input logic e_f, input logic [2:0] e_rt, input logic [7:0] e_ll);
    chk({p, ".pll_rst"},       32'(bus.pll_rst),       32'(e_pr));
    chk({p, ".sys_reset"},     32'(bus.sys_reset),     32'(e_sr));
    chk({p, ".ready"},         32'(bus.ready),         32'(e_rd));
    chk({p, ".fail"},          32'(bus.fail),          32'(e_f));
    chk({p, ".retry_cnt"},     32'(bus.retry_cnt),     32'(e_rt));
    chk({p, ".lock_loss_cnt"}, 32'(bus.lock_loss_cnt), 32'(e_ll));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic tick_count(input int n);
    for (int k = 0; k < n; k++) begin
      tick(1);
      if (bus.pll_rst && !prev_pr) rises++;
      prev_pr = bus.pll_rst;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt[7];
    //            rst  lock rstrt cyc  pr   sr   rd   f    rt    ll
    vt[0] = '{1'b1, 1'b1, 1'b0,    3, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0};
    vt[1] = '{1'b0, 1'b1, 1'b0,   16, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0};
    vt[2] = '{1'b0, 1'b1, 1'b0,    1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0};
    vt[3] = '{1'b0, 1'b1, 1'b0, 1024, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0};
    vt[4] = '{1'b0, 1'b1, 1'b0,    1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0};
    vt[5] = '{1'b0, 1'b0, 1'b0,    3, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0};
    vt[6] = '{1'b0, 1'b1, 1'b0,   10, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0};

    for (int i = 0; i < 7; i++) begin
      rst            = vt[i].rst;
      bus.pll_locked = vt[i].locked;
      bus.restart    = vt[i].restart;
      tick(vt[i].cyc);
      chk_all($sformatf("vec%0d", i), vt[i].pll_rst, vt[i].sys_reset, vt[i].ready,
              vt[i].fail, vt[i].retry, vt[i].loss);
    end

    // Four-cycle dropout in RUN: sys_reset on the 7th edge after the drop
    bus.pll_locked = 1'b0;
    tick(6);
    chk("loss4.d6.sys_reset", 32'(bus.sys_reset), 32'd0);
    chk("loss4.d6.ready", 32'(bus.ready), 32'd1);
    tick(1);
    chk_all("loss4.d7", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd1);
    bus.pll_locked = 1'b1;
    tick(1040);
    chk("relock.ready_early", 32'(bus.ready), 32'd0);
    tick(1);
    chk_all("relock", 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'd1);

    // One-cycle lock glitch halfway through SETL
    bus.restart = 1'b1;
    tick(1);
    bus.restart = 1'b0;
    tick(17 + 512);
    bus.pll_locked = 1'b0;
    tick(1);
    bus.pll_locked = 1'b1;
    tick(512);
    chk("glitch.orig_deadline.ready", 32'(bus.ready), 32'd0);
    chk("glitch.orig_deadline.sys_reset", 32'(bus.sys_reset), 32'd1);
    tick(515);
    chk("glitch.ready_early", 32'(bus.ready), 32'd0);
    tick(1);
    chk_all("glitch.run", 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'd1);

    // Lock never arrives: four reset pulses, then FAIL
    bus.pll_locked = 1'b0;
    bus.restart    = 1'b1;
    tick(1);
    bus.restart = 1'b0;
    rises   = 0;
    prev_pr = bus.pll_rst;
    tick_count(464);
    chk("timeout.pulses", 32'(rises), 32'd4);
    chk("timeout.fail_early", 32'(bus.fail), 32'd0);
    tick_count(1);
    chk_all("timeout.fail", 1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 8'd1);
    tick_count(50);
    chk("fail.hold.pulses", 32'(rises), 32'd4);
    chk("fail.hold.fail", 32'(bus.fail), 32'd1);

    // Restart out of FAIL with lock present
    bus.pll_locked = 1'b1;
    tick(5);
    bus.restart = 1'b1;
    tick(1);
    bus.restart = 1'b0;
    chk("restart.z1.fail", 32'(bus.fail), 32'd1);
    chk("restart.z1.retry", 32'(bus.retry_cnt), 32'd0);
    tick(1);
    chk("restart.z2.fail", 32'(bus.fail), 32'd0);
    chk("restart.z2.pll_rst", 32'(bus.pll_rst), 32'd1);
    tick(1040);
    chk("restart.ready_early", 32'(bus.ready), 32'd0);
    tick(1);
    chk_all("restart.run", 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'd1);

    // rst (with restart also high) mid-SETL
    bus.restart = 1'b1;
    tick(1);
    bus.restart = 1'b0;
    tick(117);
    rst            = 1'b1;
    bus.restart    = 1'b1;
    bus.pll_locked = 1'b0;
    tick(1);
    chk_all("rst_mid_setl", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
    rst         = 1'b0;
    bus.restart = 1'b0;

    // Restart in the same cycle as the second WAIT timeout
    tick(115);
    chk("wait.pre_timeout1.retry", 32'(bus.retry_cnt), 32'd0);
    tick(1);
    chk("wait.timeout1.retry", 32'(bus.retry_cnt), 32'd1);
    tick(115);
    chk("wait.pre_timeout2.retry", 32'(bus.retry_cnt), 32'd1);
    bus.restart = 1'b1;
    tick(1);
    bus.restart = 1'b0;
    chk("restart_vs_timeout.retry", 32'(bus.retry_cnt), 32'd0);
    tick(1);
    chk("restart_vs_timeout.pll_rst", 32'(bus.pll_rst), 32'd1);

    // Restart while in PRST must not stretch the pulse
    tick(3);
    bus.restart = 1'b1;
    tick(1);
    bus.restart = 1'b0;
    tick(11);
    chk("prst_restart.last_high", 32'(bus.pll_rst), 32'd1);
    tick(1);
    chk("prst_restart.low", 32'(bus.pll_rst), 32'd0);
    chk("prst_restart.retry", 32'(bus.retry_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
